// File: rtl/fnd_scan_decoder_if.sv
// FND drive bus as seen on the board: active-low segment font and
// active-low one-hot digit common. The display controller drives it; the scan decoder monitors it.
interface fnd_scan_decoder_if;
  logic [7:0] fnd_font;
  logic [3:0] fnd_comm;

  modport master (output fnd_font, output fnd_comm);
  modport slave  (input  fnd_font, input  fnd_comm);
endinterface

// File: rtl/fnd_scan_decoder.sv
// Receive end of the FND scan bus: settles each (comm, font) pair, decodes it into
// per-position digit codes and assembles one frame per full scan, with error/stale flags.
module fnd_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  fnd_scan_decoder_if.slave        fnd,
  output logic [15:0]              digits,
  output logic [3:0]               dp,
  output logic                     frame_valid,
  output logic                     seg_err,
  output logic                     comm_err,
  output logic                     stale
);
  localparam int unsigned   SW          = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned   TW          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic {S_SETTLE, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic [7:0]      font_q, font_d;
  logic [3:0]      comm_q, comm_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [3:0]      seen_q, seen_d;
  logic [3:0][3:0] cap_code_q, cap_code_d;
  logic [3:0]      cap_dp_q, cap_dp_d;
  logic [15:0]     digits_q, digits_d;
  logic [3:0]      dp_q, dp_d;
  logic            frame_valid_q, frame_valid_d;
  logic            seg_err_q, seg_err_d;
  logic            comm_err_q, comm_err_d;

  logic            changed, accept, comm_ok, seg_bad, valid_acc, frame_done;
  logic [1:0]      pos;
  logic [3:0]      code;

  // Stability is judged on the pair being sampled this edge versus the held sample,
  // so a pair sampled at edge k is accepted at edge k+SETTLE_CYCLES.
  always_comb begin
    font_d  = fnd.fnd_font;
    comm_d  = fnd.fnd_comm;
    changed = (fnd.fnd_font != font_q) || (fnd.fnd_comm != comm_q);
    state_d = state_q;
    scnt_d  = scnt_q;
    accept  = 1'b0;
    case (state_q)
      S_SETTLE: begin
        if (changed) begin
          scnt_d = '0;
        end else if (scnt_q == SETTLE_LAST) begin
          accept  = 1'b1;
          scnt_d  = '0;
          state_d = S_HOLD;
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end
      S_HOLD: begin
        if (changed) begin
          scnt_d  = '0;
          state_d = S_SETTLE;
        end
      end
      default: state_d = S_SETTLE;
    endcase
  end

  always_comb begin
    code    = 4'hE;
    seg_bad = 1'b0;
    case (font_q[6:0])
      7'h40:   code = 4'h0;
      7'h79:   code = 4'h1;
      7'h24:   code = 4'h2;
      7'h30:   code = 4'h3;
      7'h19:   code = 4'h4;
      7'h12:   code = 4'h5;
      7'h02:   code = 4'h6;
      7'h78:   code = 4'h7;
      7'h00:   code = 4'h8;
      7'h10:   code = 4'h9;
      7'h7F:   code = 4'hA;
      default: seg_bad = 1'b1;
    endcase
  end

  always_comb begin
    comm_ok = 1'b1;
    pos     = 2'd0;
    case (comm_q)
      4'b1110: pos = 2'd0;
      4'b1101: pos = 2'd1;
      4'b1011: pos = 2'd2;
      4'b0111: pos = 2'd3;
      default: comm_ok = 1'b0;
    endcase
  end

  // A completed frame is published from the pre-edge capture registers, so a capture
  // landing on the same edge starts the next frame.
  always_comb begin
    valid_acc     = accept && comm_ok;
    frame_done    = (seen_q == 4'hF);
    comm_err_d    = accept && !comm_ok;
    seg_err_d     = valid_acc && seg_bad;
    frame_valid_d = frame_done;
    digits_d      = frame_done ? cap_code_q : digits_q;
    dp_d          = frame_done ? cap_dp_q : dp_q;
    seen_d        = frame_done ? '0 : seen_q;
    cap_code_d    = cap_code_q;
    cap_dp_d      = cap_dp_q;
    if (valid_acc) begin
      seen_d[pos]     = 1'b1;
      cap_code_d[pos] = code;
      cap_dp_d[pos]   = ~font_q[7];
    end
    if (valid_acc)                 tcnt_d = '0;
    else if (tcnt_q == TIMEOUT_MAX) tcnt_d = tcnt_q;
    else                           tcnt_d = tcnt_q + TW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_SETTLE;
      font_q        <= 8'hFF;
      comm_q        <= 4'hF;
      scnt_q        <= '0;
      tcnt_q        <= '0;
      seen_q        <= '0;
      cap_code_q    <= {4{4'hA}};
      cap_dp_q      <= '0;
      digits_q      <= 16'hAAAA;
      dp_q          <= '0;
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      comm_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      font_q        <= font_d;
      comm_q        <= comm_d;
      scnt_q        <= scnt_d;
      tcnt_q        <= tcnt_d;
      seen_q        <= seen_d;
      cap_code_q    <= cap_code_d;
      cap_dp_q      <= cap_dp_d;
      digits_q      <= digits_d;
      dp_q          <= dp_d;
      frame_valid_q <= frame_valid_d;
      seg_err_q     <= seg_err_d;
      comm_err_q    <= comm_err_d;
    end
  end

  assign digits      = digits_q;
  assign dp          = dp_q;
  assign frame_valid = frame_valid_q;
  assign seg_err     = seg_err_q;
  assign comm_err    = comm_err_q;
  assign stale       = (tcnt_q == TIMEOUT_MAX);
endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Bench for fnd_scan_decoder: frame table, directed multi-cycle sequences and random
// scans, all checked every edge against a run-length based reference model.
module tb_fnd_scan_decoder;
  localparam int unsigned SETTLE = 16;
  localparam int unsigned TMO    = 1000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fnd_scan_decoder_if bus();
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        frame_valid, seg_err, comm_err, stale;

  fnd_scan_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .fnd(bus), .digits(digits), .dp(dp),
    .frame_valid(frame_valid), .seg_err(seg_err), .comm_err(comm_err), .stale(stale)
  );

  int vectors = 0;
  int miscompares = 0;
  int fv_cnt = 0, seg_cnt = 0, comm_cnt = 0;

  // Reference model: a pair is accepted on the edge where it has been sampled
  // exactly SETTLE+1 times in a row (the reset sample value counts as one sample).
  logic [7:0]  m_last_font;
  logic [3:0]  m_last_comm;
  int          m_run;
  logic [3:0]  m_cap [4];
  logic        m_cap_dp [4];
  logic        m_seen [4];
  logic [15:0] m_digits;
  logic [3:0]  m_dp;
  int          m_since;
  logic        e_fv, e_seg, e_comm;
  logic [6:0]  pats [11] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                             7'h02, 7'h78, 7'h00, 7'h10, 7'h7F};

  function automatic logic [3:0] seg_code(input logic [6:0] s);
    for (int i = 0; i < 11; i++)
      if (pats[i] == s) return (i == 10) ? 4'hA : 4'(i);
    return 4'hE;
  endfunction

  function automatic logic [3:0] comm_of(input int p);
    logic [3:0] v;
    v = 4'b1111;
    v[p] = 1'b0;
    return v;
  endfunction

  task automatic model_reset();
    m_last_font = 8'hFF;
    m_last_comm = 4'hF;
    m_run = 1;
    for (int i = 0; i < 4; i++) begin
      m_cap[i] = 4'hA; m_cap_dp[i] = 1'b0; m_seen[i] = 1'b0;
    end
    m_digits = 16'hAAAA;
    m_dp = 4'h0;
    m_since = 0;
    e_fv = 1'b0; e_seg = 1'b0; e_comm = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] f, input logic [3:0] c);
    int lows, p;
    logic [3:0] cd;
    e_fv = m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3];
    e_seg = 1'b0;
    e_comm = 1'b0;
    if (e_fv) begin
      for (int i = 0; i < 4; i++) begin
        m_digits[4*i +: 4] = m_cap[i];
        m_dp[i] = m_cap_dp[i];
        m_seen[i] = 1'b0;
      end
    end
    if (f == m_last_font && c == m_last_comm) begin
      if (m_run < int'(SETTLE) + 2) m_run++;
    end else begin
      m_run = 1; m_last_font = f; m_last_comm = c;
    end
    lows = 0; p = 0;
    for (int i = 0; i < 4; i++) if (!c[i]) begin lows++; p = i; end
    if (m_run == int'(SETTLE) + 1 && lows == 1) begin
      cd = seg_code(f[6:0]);
      e_seg = (cd == 4'hE);
      m_cap[p] = cd;
      m_cap_dp[p] = ~f[7];
      m_seen[p] = 1'b1;
      m_since = 0;
    end else begin
      e_comm = (m_run == int'(SETTLE) + 1);
      if (m_since < int'(TMO)) m_since++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [7:0] f, input logic [3:0] c);
    bus.fnd_font = f;
    bus.fnd_comm = c;
    @(posedge clk);
    model_edge(f, c);
    #1;
    if (frame_valid === 1'b1) fv_cnt++;
    if (seg_err === 1'b1) seg_cnt++;
    if (comm_err === 1'b1) comm_cnt++;
    chk("frame_valid", {31'd0, frame_valid}, {31'd0, e_fv});
    chk("seg_err", {31'd0, seg_err}, {31'd0, e_seg});
    chk("comm_err", {31'd0, comm_err}, {31'd0, e_comm});
    chk("stale", {31'd0, stale}, {31'd0, m_since == int'(TMO)});
    chk("digits", {16'd0, digits}, {16'd0, m_digits});
    chk("dp", {28'd0, dp}, {28'd0, m_dp});
  endtask

  task automatic hold(input logic [7:0] f, input logic [3:0] c, input int n);
    repeat (n) step(f, c);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_digits"}, {16'd0, digits}, 32'h0000AAAA);
    chk({tag, "_dp"}, {28'd0, dp}, 32'h0);
    chk({tag, "_flags"}, {28'd0, frame_valid, seg_err, comm_err, stale}, 32'h0);
  endtask

  typedef struct {
    logic [31:0] fonts;       // byte p = font for position p
    logic [15:0] exp_digits;
    logic [3:0]  exp_dp;
    int          exp_seg;
  } frame_vec_t;

  frame_vec_t tbl [5];

  initial begin
    int fv0, seg0, comm0, lat;
    logic [7:0] rf;
    logic [3:0] rc;

    tbl[0] = '{32'h99B0A4F9, 16'h4321, 4'b0000, 0};
    tbl[1] = '{32'hC07FC040, 16'h0A00, 4'b0101, 0};
    tbl[2] = '{32'h80F88292, 16'h8765, 4'b0000, 0};
    tbl[3] = '{32'h002AFF90, 16'h8EA9, 4'b1100, 1};
    tbl[4] = '{32'h30247919, 16'h3214, 4'b1111, 0};

    bus.fnd_font = 8'hFF;
    bus.fnd_comm = 4'hF;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk_reset_outputs("reset_init");

    // Full-frame decode table
    foreach (tbl[r]) begin
      fv0 = fv_cnt; seg0 = seg_cnt;
      for (int p = 0; p < 4; p++) hold(tbl[r].fonts[8*p +: 8], comm_of(p), 30);
      chk("tbl_frame_count", fv_cnt - fv0, 1);
      chk("tbl_seg_count", seg_cnt - seg0, tbl[r].exp_seg);
      chk("tbl_digits", {16'd0, digits}, {16'd0, tbl[r].exp_digits});
      chk("tbl_dp", {28'd0, dp}, {28'd0, tbl[r].exp_dp});
    end

    // Timeout: last valid acceptance on the 17th edge of 1110/C0
    hold(8'hC0, 4'b1110, 17);
    comm0 = comm_cnt;
    for (int n = 1; n <= int'(TMO); n++) begin
      step(8'hFF, 4'b1111);
      if (n == int'(TMO) - 1) chk("stale_before_timeout", {31'd0, stale}, 32'd0);
      if (n == int'(TMO))     chk("stale_at_timeout", {31'd0, stale}, 32'd1);
    end
    chk("comm_err_1111_once", comm_cnt - comm0, 1);
    for (int n = 1; n <= 20; n++) begin
      step(8'hC0, 4'b1110);
      if (n == int'(SETTLE))     chk("stale_until_accept", {31'd0, stale}, 32'd1);
      if (n == int'(SETTLE) + 1) chk("stale_clear_on_accept", {31'd0, stale}, 32'd0);
    end

    // Illegal common, then undecodable segments
    fv0 = fv_cnt; comm0 = comm_cnt;
    hold(8'hC0, 4'b1100, 50);
    chk("comm_err_multi_low", comm_cnt - comm0, 1);
    chk("no_frame_on_bad_comm", fv_cnt - fv0, 0);
    seg0 = seg_cnt;
    hold(8'hAA, 4'b1101, 30);
    chk("seg_err_pulse", seg_cnt - seg0, 1);
    hold(8'hC0, 4'b1011, 30);
    hold(8'hC0, 4'b0111, 30);
    chk("seg_frame_count", fv_cnt - fv0, 1);
    chk("seg_frame_digits", {16'd0, digits}, 32'h000000E0);

    // Glitch during hold, then capture-to-frame latency
    hold(8'hF9, 4'b1110, 50);
    hold(8'hFF, 4'b1110, 5);
    hold(8'hF9, 4'b1110, 30);
    hold(8'hA4, 4'b1101, 30);
    hold(8'hB0, 4'b1011, 30);
    fv0 = fv_cnt; lat = 0;
    for (int n = 1; n <= 40; n++) begin
      step(8'h99, 4'b0111);
      if (lat == 0 && fv_cnt != fv0) lat = n;
    end
    chk("frame_latency", lat, int'(SETTLE) + 2);
    chk("glitch_frame_digits", {16'd0, digits}, 32'h00004321);
    chk("glitch_frame_dp", {28'd0, dp}, 32'h0);

    // Asynchronous reset discards a partial frame
    hold(8'hF9, 4'b1110, 20);
    hold(8'hA4, 4'b1101, 20);
    #3 reset = 1'b1;
    #1 chk_reset_outputs("reset_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    fv0 = fv_cnt;
    hold(8'hB0, 4'b1011, 20);
    hold(8'h99, 4'b0111, 30);
    chk("no_frame_after_reset", fv_cnt - fv0, 0);
    hold(8'hF9, 4'b1110, 20);
    hold(8'hA4, 4'b1101, 30);
    chk("frame_after_rescan", fv_cnt - fv0, 1);
    chk("rescan_digits", {16'd0, digits}, 32'h00004321);

    // Random scans with glitches, illegal commons and arbitrary fonts
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 9) == 0) begin
        rc = 4'($urandom_range(0, 15));
        if ($countones(~rc) == 1) rc = 4'b0000;
      end else begin
        rc = comm_of(int'($urandom_range(0, 3)));
      end
      if ($urandom_range(0, 9) < 7) rf = {1'($urandom_range(0, 1)), pats[$urandom_range(0, 10)]};
      else rf = 8'($urandom_range(0, 255));
      hold(rf, rc, int'($urandom_range(1, 24)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fnd_scan_decoder.md
# fnd_scan_decoder

Monitors the multiplexed 4-digit FND drive (fnd_font / fnd_comm) and reconstructs the displayed content into per-digit codes and decimal-point flags. It filters scan-transition glitches, assembles one complete frame per full scan cycle, and flags illegal segment or common patterns. It sits beside the display controller as the receive end of the FND interface, for on-chip self-check and for reporting displayed content over UART.

## Interface
- SETTLE_CYCLES, 16: consecutive clocks an unchanged (fnd_comm, fnd_font) pair must hold before acceptance; range 1..255.
- TIMEOUT_CYCLES, 1_000_000: clocks without an accepted sample before stale is raised.
- clk  input  1  system clock (100 MHz nominal).
- reset  input  1  reset, asynchronous, active-high.
- fnd_font  input  8  segment drive, active-low; bit 7 = dp, bits 6:0 = g..a.
- fnd_comm  input  4  digit common, active-low one-hot; bit n low selects position n (0 = rightmost).
- digits  output  16  frame digit codes, position n at [4n+3:4n]; 0..9 numerals, 0xA blank, 0xE invalid.
- dp  output  4  frame decimal-point flags, bit n = position n lit.
- frame_valid  output  1  1-cycle pulse when digits/dp update.
- seg_err  output  1  1-cycle pulse when an undecodable segment pattern is accepted.
- comm_err  output  1  1-cycle pulse when a stable fnd_comm is not one-hot-low.
- stale  output  1  level; high when no sample accepted for TIMEOUT_CYCLES.

## Operation
- Input stage: fnd_font and fnd_comm registered once (sample regs) each clock; all decoding uses the registered values.
- Settle FSM, two states:
  - S_SETTLE: settle counter increments while the sample pair equals the previous sample pair, reloads to 0 on any change. On reaching SETTLE_CYCLES-1 with the pair unchanged, the pair is accepted and the FSM moves to S_HOLD.
  - S_HOLD: no further acceptance. Any change in the sample pair returns the FSM to S_SETTLE with the counter at 0.
  - Each stable period is accepted exactly once.
- Acceptance with fnd_comm one-hot-low (1110, 1101, 1011, 0111) writes position n of the capture registers and sets seen[n]:
  - dp_cap[n] = ~font[7].
  - Code from font[6:0]: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 7F->0xA (blank).
  - Any other font[6:0] -> 0xE, with seg_err pulsed on the same edge as the capture write.
  - A repeat capture of a position before frame completion overwrites the earlier value.
- Acceptance with any other fnd_comm (0000, multiple lows, 1111):
  - comm_err pulses.
  - No capture, no change to seen; the timeout counter is not cleared.
- Frame completion: when seen = 1111, on the next edge:
  - digits and dp load from the capture registers.
  - frame_valid pulses for 1 cycle.
  - seen clears.
  - If a capture lands on that same edge, it is recorded into the new frame (seen gets only that bit).
- Timeout counter: cleared on every valid-comm acceptance, otherwise increments and saturates at TIMEOUT_CYCLES.
  - stale = 1 while the counter is at TIMEOUT_CYCLES.
  - stale drops on the edge of the next valid-comm acceptance.
- Width rules: settle counter is $clog2(SETTLE_CYCLES+1) bits; timeout counter is $clog2(TIMEOUT_CYCLES+1) bits. Neither counter wraps.

## Timing
- Reset values:
  - digits = 16'hAAAA; dp = 0.
  - frame_valid = seg_err = comm_err = stale = 0.
  - seen = 0; FSM = S_SETTLE; all counters = 0; capture regs = 0xA / 0.
- Latency, raw input to capture: a pair first presented before edge k (sampled at k) is captured at edge k+SETTLE_CYCLES, provided it stays unchanged through that edge. A change at any point restarts the count.
- Glitch rejection: any pair lasting fewer than SETTLE_CYCLES sampled clocks is never accepted.
- Capture to output: frame_valid and the digits/dp update occur 1 edge after the capture that completes seen.
- Reset mid-operation is asynchronous: all state returns to reset values immediately, and partial frames are discarded.

## Test plan
- Scan comm 1110/F9, 1101/A4, 1011/B0, 0111/99, each held 50 clocks, SETTLE_CYCLES=16 -> single frame_valid; digits=16'h4321, dp=0. The frame_valid edge falls 17 edges after the 0111 pair is first sampled.
- Mid-hold of 1110/F9, font glitches to 0xFF for 5 clocks then returns to F9 -> no capture of 0xFF; F9 is re-accepted once after a fresh 16-clock settle.
- Dot and blank: 1011/7F and 1110/40 (dp lit, digit 0) in a full scan with 1101/C0, 0111/C0 -> digits=16'h0A00, dp=4'b0101.
- comm 1100 with font C0 held 50 clocks -> exactly one comm_err pulse, seen unchanged. Then 1101/AA -> seg_err pulse and position 1 = 0xE in the next frame.
- TIMEOUT_CYCLES=1000, inputs frozen at 1111/FF after a valid capture -> stale rises 1000 edges after the last acceptance. Next valid 1110/C0 acceptance -> stale=0 on that edge.
- Assert reset after positions 0 and 1 captured -> outputs return to reset values. After release, frame_valid does not fire until all four positions are captured again.
